// File: rtl/vigna_irq_ctrl_if.sv
// vigna_irq_ctrl_if -- data-bus port of the interrupt controller.
// Same valid/ready/wstrb protocol as the core's d_* port.
//   s_valid  master->slave  request
//   s_ready  slave->master  one-cycle completion pulse
//   s_addr   master->slave  byte address, bits [1:0] ignored
//   s_wdata  master->slave  write data
//   s_wstrb  master->slave  nonzero = write, zero = read
//   s_rdata  slave->master  read data, valid while s_ready=1
interface vigna_irq_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;

  modport master (output s_valid, s_addr, s_wdata, s_wstrb, input s_ready, s_rdata);
  modport slave  (input s_valid, s_addr, s_wdata, s_wstrb, output s_ready, s_rdata);
endinterface

// File: rtl/vigna_irq_ctrl.sv
// vigna_irq_ctrl -- N_SRC-source prioritised external-interrupt controller
// driving the core's ext_irq input.
//   clk      system clock
//   reset    asynchronous, active-high reset
//   irq_src  raw source lines, bit i-1 = source ID i (asynchronous to clk)
//   bus      slave side of the data bus (PENDING/ENABLE/MODE/THRESHOLD/
//            CLAIM-COMPLETE/PRIORITY registers)
//   ext_irq  registered interrupt request (best eligible ID != 0)
module vigna_irq_ctrl #(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned PRIO_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     irq_src,
  vigna_irq_ctrl_if.slave      bus,
  output logic                 ext_irq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ext_irq_q, ext_irq_d;
  logic [N_SRC-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [N_SRC-1:0]  pend_q, pend_d, insvc_q, insvc_d;
  logic [N_SRC-1:0]  en_q, en_d, mode_q, mode_d;
  logic [PRIO_W-1:0] thr_q, thr_d;
  logic [PRIO_W-1:0] prio_q [N_SRC];
  logic [PRIO_W-1:0] prio_d [N_SRC];

  logic [5:0]        word;
  logic              access, wr, rd;
  logic [N_SRC-1:0]  elig, pend_set, pend_clr, insvc_set, insvc_clr;
  logic [4:0]        best;
  logic [PRIO_W-1:0] best_prio;
  logic [31:0]       rdata_v;
  logic              unused_addr;

  assign unused_addr = ^bus.s_addr[1:0];

  always_comb begin
    word   = bus.s_addr[7:2];
    access = (state_q == ST_IDLE) && bus.s_valid;
    wr     = access && (bus.s_wstrb != '0);
    rd     = access && (bus.s_wstrb == '0);

    sync1_d = irq_src;
    sync2_d = sync1_q;
    sync3_d = sync2_q;

    // Arbitration: strict '>' keeps the lowest ID on equal priority.
    best      = '0;
    best_prio = '0;
    elig      = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      elig[i] = pend_q[i] & en_q[i] & ~insvc_q[i] & (prio_q[i] > thr_q);
      if (elig[i] && ((best == '0) || (prio_q[i] > best_prio))) begin
        best      = 5'(i + 1);
        best_prio = prio_q[i];
      end
    end

    // Read mux reflects state before this edge's updates.
    rdata_v = '0;
    case (word)
      6'd0: rdata_v[N_SRC:1]    = pend_q;
      6'd1: rdata_v[N_SRC:1]    = en_q;
      6'd2: rdata_v[N_SRC:1]    = mode_q;
      6'd3: rdata_v[PRIO_W-1:0] = thr_q;
      6'd4: rdata_v[4:0]        = best;
      default: begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
          if (32'(word) == i + 32'd9) rdata_v[PRIO_W-1:0] = prio_q[i];
        end
      end
    endcase

    en_d   = en_q;
    mode_d = mode_q;
    thr_d  = thr_q;
    prio_d = prio_q;
    if (wr) begin
      case (word)
        6'd1: en_d   = bus.s_wdata[N_SRC:1];
        6'd2: mode_d = bus.s_wdata[N_SRC:1];
        6'd3: thr_d  = bus.s_wdata[PRIO_W-1:0];
        default: begin
          for (int unsigned i = 0; i < N_SRC; i++) begin
            if (32'(word) == i + 32'd9) prio_d[i] = bus.s_wdata[PRIO_W-1:0];
          end
        end
      endcase
    end

    // Claim (read of 0x10) and complete (write of 0x10).
    pend_clr  = '0;
    insvc_set = '0;
    insvc_clr = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (rd && (word == 6'd4) && (best == 5'(i + 1))) begin
        pend_clr[i]  = 1'b1;
        insvc_set[i] = 1'b1;
      end
      if (wr && (word == 6'd4) && (bus.s_wdata == i + 32'd1)) insvc_clr[i] = 1'b1;
    end
    insvc_d = (insvc_q & ~insvc_clr) | insvc_set;

    // Level sources gate on next-cycle in_service so that the claiming edge
    // clears pending instead of being overridden by the still-high line, and
    // the completing edge re-pends a line that is still high.
    for (int unsigned i = 0; i < N_SRC; i++) begin
      pend_set[i] = mode_q[i] ? (sync2_q[i] & ~sync3_q[i])
                              : (sync2_q[i] & ~insvc_d[i]);
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;

    rdata_d   = access ? rdata_v : rdata_q;
    state_d   = access ? ST_ACK : ST_IDLE;
    ext_irq_d = (best != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rdata_q   <= '0;
      ext_irq_q <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      pend_q    <= '0;
      insvc_q   <= '0;
      en_q      <= '0;
      mode_q    <= '0;
      thr_q     <= '0;
      for (int unsigned i = 0; i < N_SRC; i++) prio_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      ext_irq_q <= ext_irq_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      pend_q    <= pend_d;
      insvc_q   <= insvc_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      thr_q     <= thr_d;
      prio_q    <= prio_d;
    end
  end

  assign bus.s_ready = (state_q == ST_ACK);
  assign bus.s_rdata = rdata_q;
  assign ext_irq     = ext_irq_q;

endmodule

// File: tb/tb_vigna_irq_ctrl.sv
module tb_vigna_irq_ctrl;
  localparam int unsigned N_SRC  = 8;
  localparam int unsigned PRIO_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_SRC-1:0] irq_src = '0;
  logic             ext_irq;
  int               n_chk = 0;
  int               n_pass = 0;
  logic [31:0]      d;

  vigna_irq_ctrl_if bus_if ();

  vigna_irq_ctrl #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .bus     (bus_if),
    .ext_irq (ext_irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic xfer(input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rdata);
    int n = 0;
    bus_if.s_valid = 1'b1;
    bus_if.s_addr  = addr;
    bus_if.s_wdata = wdata;
    bus_if.s_wstrb = wstrb;
    do begin
      tick(1);
      n++;
    end while (!bus_if.s_ready && n < 8);
    if (!bus_if.s_ready) check("bus_timeout", {31'b0, bus_if.s_ready}, 32'd1);
    rdata = bus_if.s_rdata;
    bus_if.s_valid = 1'b0;
    bus_if.s_wstrb = '0;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] rdata);
    xfer(addr, 32'd0, 4'b0000, rdata);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    xfer(addr, wdata, 4'b1111, dummy);
  endtask

  initial begin
    bus_if.s_valid = 1'b0;
    bus_if.s_addr  = '0;
    bus_if.s_wdata = '0;
    bus_if.s_wstrb = '0;
    tick(3);
    check("rst_ready", {31'b0, bus_if.s_ready}, 32'd0);
    check("rst_rdata", bus_if.s_rdata, 32'd0);
    check("rst_ext_irq", {31'b0, ext_irq}, 32'd0);
    reset = 1'b0;
    tick(1);
    rd(8'h00, d); check("rst_pending", d, 32'h0);
    rd(8'h04, d); check("rst_enable", d, 32'h0);

    // Bus corners (all priorities still 0)
    rd(8'h3C, d); check("rd_3c", d, 32'h0);
    tick(1); check("ready_one_cycle", {31'b0, bus_if.s_ready}, 32'd0);
    wr(8'h04, 32'hFFFF_FFFF);
    rd(8'h04, d); check("enable_mask", d, 32'h1FE);
    wr(8'h08, 32'hFFFF_FFFF);
    rd(8'h08, d); check("mode_mask", d, 32'h1FE);
    wr(8'h0C, 32'hFFFF_FFFF);
    rd(8'h0C, d); check("thr_mask", d, 32'h7);
    wr(8'h14, 32'hFFFF_FFFF);
    rd(8'h14, d); check("unmapped_14", d, 32'h0);
    rd(8'h44, d); check("unmapped_44", d, 32'h0);

    // Edge source ID2
    wr(8'h04, 32'h004);
    wr(8'h08, 32'h004);
    wr(8'h28, 32'd3);
    wr(8'h0C, 32'd0);
    rd(8'h28, d); check("prio2", d, 32'd3);
    irq_src[1] = 1'b1;
    tick(1);
    irq_src[1] = 1'b0;
    tick(2); check("edge_irq_early", {31'b0, ext_irq}, 32'd0);
    tick(1); check("edge_irq_4edges", {31'b0, ext_irq}, 32'd1);
    rd(8'h00, d); check("edge_pending", d, 32'h004);
    rd(8'h10, d); check("edge_claim", d, 32'd2);
    tick(1); check("edge_irq_drop", {31'b0, ext_irq}, 32'd0);
    rd(8'h00, d); check("edge_pending_clr", d, 32'h0);

    // Second edge while ID2 in service
    irq_src[1] = 1'b1;
    tick(1);
    irq_src[1] = 1'b0;
    tick(4);
    rd(8'h00, d); check("svc_pending", d, 32'h004);
    check("svc_irq_low", {31'b0, ext_irq}, 32'd0);
    wr(8'h10, 32'd9);
    tick(3); check("complete_id9", {31'b0, ext_irq}, 32'd0);
    wr(8'h10, 32'd2);
    tick(1); check("svc_irq_after_cpl", {31'b0, ext_irq}, 32'd1);
    rd(8'h10, d); check("svc_claim", d, 32'd2);
    wr(8'h10, 32'd2);
    tick(1); check("svc_irq_idle", {31'b0, ext_irq}, 32'd0);

    // Priority / tie: IDs 3,5 at 4, ID 7 at 6
    wr(8'h04, 32'h0A8);
    wr(8'h08, 32'h0A8);
    wr(8'h2C, 32'd4);
    wr(8'h34, 32'd4);
    wr(8'h3C, 32'd6);
    irq_src = 8'h54;
    tick(1);
    irq_src = '0;
    tick(4);
    rd(8'h00, d); check("prio_pending", d, 32'h0A8);
    rd(8'h10, d); check("claim_7", d, 32'd7);
    wr(8'h10, 32'd7);
    rd(8'h10, d); check("claim_3", d, 32'd3);
    wr(8'h10, 32'd3);
    rd(8'h10, d); check("claim_5", d, 32'd5);
    wr(8'h10, 32'd5);
    rd(8'h10, d); check("claim_none", d, 32'd0);
    tick(1); check("prio_irq_idle", {31'b0, ext_irq}, 32'd0);

    // Threshold: ID1 prio 2, threshold 2
    wr(8'h04, 32'h002);
    wr(8'h08, 32'h002);
    wr(8'h24, 32'd2);
    wr(8'h0C, 32'd2);
    irq_src[0] = 1'b1;
    tick(1);
    irq_src[0] = 1'b0;
    tick(5);
    rd(8'h00, d); check("thr_pending", d, 32'h002);
    check("thr_irq_blocked", {31'b0, ext_irq}, 32'd0);
    wr(8'h0C, 32'd1);
    tick(1); check("thr_irq_open", {31'b0, ext_irq}, 32'd1);
    rd(8'h10, d); check("thr_claim", d, 32'd1);
    wr(8'h10, 32'd1);
    wr(8'h0C, 32'd0);

    // Level source ID4
    wr(8'h04, 32'h010);
    wr(8'h08, 32'h000);
    wr(8'h30, 32'd5);
    irq_src[3] = 1'b1;
    tick(4); check("lvl_irq", {31'b0, ext_irq}, 32'd1);
    rd(8'h10, d); check("lvl_claim", d, 32'd4);
    tick(3);
    rd(8'h00, d); check("lvl_no_repend", d, 32'h0);
    check("lvl_irq_svc", {31'b0, ext_irq}, 32'd0);
    wr(8'h10, 32'd4);
    tick(1); check("lvl_irq_reassert", {31'b0, ext_irq}, 32'd1);
    rd(8'h00, d); check("lvl_repend", d, 32'h010);
    rd(8'h10, d); check("lvl_claim2", d, 32'd4);
    irq_src[3] = 1'b0;
    tick(3);
    wr(8'h10, 32'd4);
    tick(2); check("lvl_dropped_irq", {31'b0, ext_irq}, 32'd0);
    rd(8'h00, d); check("lvl_dropped_pend", d, 32'h0);

    // Reset in the middle of ACK
    irq_src[3] = 1'b1;
    tick(4);
    bus_if.s_valid = 1'b1;
    bus_if.s_addr  = 8'h04;
    bus_if.s_wstrb = 4'b0000;
    tick(1);
    check("ack_ready", {31'b0, bus_if.s_ready}, 32'd1);
    check("ack_rdata", bus_if.s_rdata, 32'h010);
    check("ack_irq", {31'b0, ext_irq}, 32'd1);
    reset = 1'b1;
    #1;
    check("midack_ready", {31'b0, bus_if.s_ready}, 32'd0);
    check("midack_rdata", bus_if.s_rdata, 32'd0);
    check("midack_irq", {31'b0, ext_irq}, 32'd0);
    bus_if.s_valid = 1'b0;
    irq_src = '0;
    tick(2);
    reset = 1'b0;
    tick(1);
    rd(8'h04, d); check("post_rst_enable", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vigna_irq_ctrl.md
Name: vigna_irq_ctrl

Overview:
- Parametrised external-interrupt controller feeding the core's `ext_irq` input; generalises the single-wire interrupt line to N_SRC prioritised sources.
- Per-source edge/level mode, enable, priority, global threshold, claim/complete handshake.
- Sits on the data bus beside data memory, using the same valid/ready/wstrb protocol as the core's `d_*` port.

Parameters:
- N_SRC, 8, number of sources; IDs 1..N_SRC, legal 1..31; ID 0 means "none".
- PRIO_W, 3, priority/threshold width in bits; priority 0 = never interrupts.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq_src  in  N_SRC  raw source lines; bit i-1 = source ID i; asynchronous to clk
- s_valid  in  1  bus request
- s_ready  out  1  one-cycle completion pulse
- s_addr  in  8  byte address; bits [1:0] ignored
- s_wdata  in  32  write data
- s_wstrb  in  4  nonzero = write, zero = read
- s_rdata  out  32  read data, valid while s_ready=1
- ext_irq  out  1  registered interrupt request to core

Behaviour:
- Reset (async) values:
  - s_ready=0, s_rdata=0, ext_irq=0.
  - All sync flops, pending, in_service, ENABLE, MODE, THRESHOLD, PRIORITY = 0.
- Input sync: 2-flop synchroniser per source, plus a third flop for edge detection.
- Gateway, per source:
  - MODE=1 (edge): pending set on synchronised 0->1.
  - MODE=0 (level): pending set whenever the synchronised level is 1 and in_service=0.
  - Pending is cleared only by a claim of that ID.
  - If set and clear hit the same cycle, set wins.
- Eligibility: eligible[i] = pending & ENABLE & ~in_service & (PRIORITY[i] > THRESHOLD).
- Arbitration (combinational): best = eligible ID with highest priority; ties go to the lowest ID; 0 if none.
- ext_irq: registered `(best != 0)`. It rises 4 clk edges after the edge at which irq_src is first sampled high.
- Register map (word offsets):
  - 0x00 PENDING: RO, bits [N_SRC:1].
  - 0x04 ENABLE: RW, bits [N_SRC:1].
  - 0x08 MODE: RW, bits [N_SRC:1].
  - 0x0C THRESHOLD: RW, bits [PRIO_W-1:0].
  - 0x10 CLAIM/COMPLETE:
    - Read returns `best`. If nonzero, clears pending[best] and sets in_service[best] atomically.
    - Write of ID clears in_service[ID].
    - ID 0, ID > N_SRC, or an ID not in service: ignored.
  - 0x20+4*i PRIORITY[i], i=1..N_SRC: RW, bits [PRIO_W-1:0].
  - All other addresses: read 0, write ignored, still acknowledged.
  - Unimplemented bits read 0.
  - Bit 0 of the bit-vector registers is hardwired 0.
- Bus handshake:
  - States IDLE/ACK.
  - IDLE: s_valid=1 -> perform access at this edge (side effects once), latch s_rdata, go to ACK with s_ready=1.
  - ACK: s_ready=1 for exactly one cycle -> IDLE.
  - s_valid held high through ACK starts a new transaction on the next IDLE cycle. The master must drop s_valid on seeing s_ready unless it intends back-to-back access.
  - Any nonzero s_wstrb is a full-word write; byte lanes are not honoured.
- Reads reflect state before the same-edge write/claim update.
- A claim uses the `best` value computed from state at the accepting edge.
- Config writes (ENABLE/PRIORITY/THRESHOLD) affect ext_irq from the next registered update. No retroactive clearing of pending.
- Disabling a source keeps its pending bit; re-enabling re-arbitrates.
- Reset mid-transaction: s_ready drops immediately. The transaction is lost; the master must restart.

Test Plan:
- Edge source:
  - Setup: N_SRC=8, ENABLE=0x004 (ID2), MODE=0x004, PRIORITY[2]=3, THRESHOLD=0.
  - Stimulus: pulse irq_src[1] for 1 cycle.
  - Required: ext_irq=1 after 4 edges; CLAIM read returns 2; ext_irq=0 next cycle; PENDING=0.
  - Then write 2 to 0x10; in_service cleared.
- Priority/tie:
  - Setup: IDs 3 and 5 both pending at priority 4, ID 7 at priority 6.
  - Required: claims return 7, then 3, then 5 (with completes between); a fourth claim returns 0.
- Threshold:
  - Setup: ID1 priority 2, THRESHOLD=2.
  - Required: pending=1 but ext_irq stays 0; write THRESHOLD=1 -> ext_irq=1 within 2 cycles.
- Level source:
  - Setup: ID4 level, held high.
  - Required: claim returns 4; no re-pend while in service; complete -> pending re-sets and ext_irq re-asserts.
  - Drop the line before complete -> no re-assert.
- Edge during service:
  - Stimulus: second edge on claimed ID2 before complete.
  - Required: PENDING bit2=1, ext_irq=0 until complete, then ext_irq=1.
- Bus corners:
  - Read 0x3C on N_SRC=8 -> 0. Write ENABLE=0xFFFFFFFF -> reads 0x1FE.
  - Complete with ID 9 -> no change.
  - s_ready is exactly one cycle per access.
  - Assert reset mid-ACK -> all outputs 0 immediately.
